// File: rtl/debug_uart_unit.sv
// Debug UART unit: run/step control of the pipeline over UART
// and a little-endian dump of the debug bus plus cycle count.
module debug_uart_unit #(
  parameter int DEBUG_W = 322,
  parameter int NB_DBG  = 41
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DEBUG_W-1:0] debug_signal,
  input  logic               halt,
  input  logic [7:0]         rx_data,
  input  logic               rx_empty,
  output logic               rd_uart,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [7:0]         tx_data,
  output logic               enable
);

  localparam int NB_TOT = NB_DBG + 4;
  localparam int SW     = NB_TOT * 8;
  localparam int IW     = $clog2(NB_TOT + 1);
  localparam logic [IW-1:0] LAST = IW'(NB_TOT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    SEND
  } state_t;

  state_t            state, state_n;
  logic              enable_n, rd_n, wr_n;
  logic              loaded, loaded_n;
  logic [7:0]        tx_n;
  logic [31:0]       cycle_count, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [SW-1:0]     shreg, shreg_n;
  logic [NB_DBG*8-1:0] dbg_pad;

  // zero-extend the debug bus to a whole number of bytes
  always_comb begin
    dbg_pad = '0;
    dbg_pad[DEBUG_W-1:0] = debug_signal;
  end

  // next-state and next-output logic; every output is registered
  always_comb begin
    state_n  = state;
    enable_n = enable;
    rd_n     = 1'b0;
    wr_n     = 1'b0;
    tx_n     = tx_data;
    loaded_n = loaded;
    idx_n    = idx;
    shreg_n  = shreg;
    cnt_n    = cycle_count + 32'(enable);
    unique case (state)
      IDLE: begin
        enable_n = 1'b0;
        loaded_n = 1'b0;
        idx_n    = '0;
        // skip the edge where the previous pop is still in flight
        if (!rx_empty && !rd_uart) begin
          rd_n = 1'b1;
          unique case (1'b1)
            (rx_data == 8'h63): begin
              state_n  = RUN;
              enable_n = 1'b1;
            end
            (rx_data == 8'h73): begin
              state_n  = STEP;
              enable_n = 1'b1;
            end
            (rx_data == 8'h64): state_n = SEND;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (halt) begin
          enable_n = 1'b0;
          state_n  = SEND;
        end
      end
      STEP: begin
        enable_n = 1'b0;
        state_n  = SEND;
      end
      SEND: begin
        enable_n = 1'b0;
        // first SEND cycle: pipeline and counter are frozen, snapshot
        if (!loaded) begin
          shreg_n  = {cycle_count, dbg_pad};
          loaded_n = 1'b1;
        end else if (!tx_full) begin
          wr_n    = 1'b1;
          tx_n    = shreg[7:0];
          shreg_n = shreg >> 8;
          idx_n   = idx + 1'b1;
          if (idx == LAST) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      enable      <= 1'b0;
      rd_uart     <= 1'b0;
      wr_uart     <= 1'b0;
      tx_data     <= 8'h00;
      loaded      <= 1'b0;
      cycle_count <= '0;
      idx         <= '0;
      shreg       <= '0;
    end else begin
      state       <= state_n;
      enable      <= enable_n;
      rd_uart     <= rd_n;
      wr_uart     <= wr_n;
      tx_data     <= tx_n;
      loaded      <= loaded_n;
      cycle_count <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
    end
  end

endmodule

// File: tb/tb_debug_uart_unit.sv
// Bench for debug_uart_unit: queue-based RX/TX models, a byte
// scoreboard fed at command issue and drained by a monitor.
module tb_debug_uart_unit;

  localparam int DEBUG_W = 322;
  localparam int NB_DBG  = 41;
  localparam int NB_TOT  = NB_DBG + 4;

  logic               clock = 1'b0;
  logic               reset;
  logic [DEBUG_W-1:0] debug_signal;
  logic               halt;
  logic [7:0]         rx_data;
  logic               rx_empty;
  logic               rd_uart;
  logic               tx_full;
  logic               wr_uart;
  logic [7:0]         tx_data;
  logic               enable;

  debug_uart_unit #(.DEBUG_W(DEBUG_W), .NB_DBG(NB_DBG)) dut (
    .clock(clock), .reset(reset), .debug_signal(debug_signal),
    .halt(halt), .rx_data(rx_data), .rx_empty(rx_empty),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart),
    .tx_data(tx_data), .enable(enable)
  );

  always #5 clock = ~clock;

  logic [7:0]  rxq[$];
  logic [7:0]  expq[$];
  logic [7:0]  dmy;
  logic [31:0] cnt_model;
  int vecs = 0, errs = 0;
  int wr_cnt = 0, rd_cnt = 0, en_cnt = 0;
  int run_seen = 0, run_target = 0;
  bit run_arm = 0, rand_full = 0;
  logic full_q = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX FIFO pop and record of the tx_full value each edge sampled
  always @(posedge clock) begin
    full_q <= tx_full;
    if (rd_uart && !reset && rxq.size() > 0) dmy = rxq.pop_front();
  end

  // random TX backpressure when enabled
  always @(posedge clock) begin
    if (rand_full) begin
      #1 tx_full = ($urandom_range(0, 3) == 0);
    end
  end

  // monitor: FIFO status, pulse counters, halt timing, scoreboard
  always @(negedge clock) begin
    rx_empty = (rxq.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rxq[0];
    if (!reset) begin
      if (rd_uart) rd_cnt++;
      if (enable) begin
        en_cnt++;
        if (run_arm) begin
          run_seen++;
          if (run_seen == run_target) halt = 1'b1;
        end
      end
      if (full_q) chk("stall_no_wr", longint'(wr_uart), 0);
      if (wr_uart) begin
        wr_cnt++;
        if (expq.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL tx_extra: got %0h expected no byte", tx_data);
        end else begin
          chk("tx_byte", longint'(tx_data), longint'(expq.pop_front()));
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // expected frame from the rules: padded debug bytes LSB first, then count
  task automatic push_frame();
    logic [NB_DBG*8-1:0] p;
    p = '0;
    p[DEBUG_W-1:0] = debug_signal;
    for (int k = 0; k < NB_DBG; k++) expq.push_back(p[8*k +: 8]);
    for (int k = 0; k < 4; k++) expq.push_back(cnt_model[8*k +: 8]);
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || rxq.size() != 0) && n < 3000) begin
      cyc(1);
      n++;
    end
    if (n >= 3000) begin
      vecs++;
      errs++;
      $display("FAIL %s_timeout: got %0d bytes left expected 0",
               name, expq.size());
      expq.delete();
    end
    cyc(4);
  endtask

  task automatic rand_debug();
    for (int i = 0; i < DEBUG_W; i++) debug_signal[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_dump();
    int w0;
    w0 = wr_cnt;
    push_frame();
    rxq.push_back(8'h64);
    wait_idle("dump");
    chk("dump_len", wr_cnt - w0, NB_TOT);
  endtask

  task automatic do_step();
    int w0, e0;
    w0 = wr_cnt;
    e0 = en_cnt;
    cnt_model = cnt_model + 1;
    push_frame();
    rxq.push_back(8'h73);
    wait_idle("step");
    chk("step_en", en_cnt - e0, 1);
    chk("step_len", wr_cnt - w0, NB_TOT);
  endtask

  task automatic do_run(int n, bit pre);
    int w0, e0;
    w0 = wr_cnt;
    e0 = en_cnt;
    cnt_model = cnt_model + 32'(n);
    halt = pre;
    run_seen = 0;
    run_target = n;
    run_arm = 1;
    push_frame();
    rxq.push_back(8'h63);
    wait_idle("run");
    run_arm = 0;
    halt = 1'b0;
    chk("run_en", en_cnt - e0, n);
    chk("run_len", wr_cnt - w0, NB_TOT);
  endtask

  task automatic do_bad(logic [7:0] b);
    int w0, e0, r0;
    w0 = wr_cnt;
    e0 = en_cnt;
    r0 = rd_cnt;
    rxq.push_back(b);
    cyc(8);
    chk("bad_rd", rd_cnt - r0, 1);
    chk("bad_wr", wr_cnt - w0, 0);
    chk("bad_en", en_cnt - e0, 0);
  endtask

  task automatic chk_zero(string name);
    chk({name, "_en"}, longint'(enable), 0);
    chk({name, "_rd"}, longint'(rd_uart), 0);
    chk({name, "_wr"}, longint'(wr_uart), 0);
    chk({name, "_tx"}, longint'(tx_data), 0);
  endtask

  task automatic mid_reset(string name);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 chk_zero(name);
    expq.delete();
    rxq.delete();
    cnt_model = '0;
    run_arm = 0;
    halt = 1'b0;
    cyc(2);
    chk_zero({name, "_hold"});
    reset = 1'b0;
    cyc(2);
  endtask

  initial begin
    logic [NB_DBG*8-1:0] p;
    int w0, n, c;
    reset = 1'b1;
    halt = 1'b0;
    tx_full = 1'b0;
    rx_empty = 1'b1;
    rx_data = 8'h00;
    debug_signal = '0;
    cnt_model = '0;
    cyc(3);
    chk_zero("reset");
    reset = 1'b0;
    cyc(2);

    // byte k of the bus carries k; the top byte keeps only 2 real bits
    p = '0;
    for (int k = 0; k < NB_DBG; k++) p[8*k +: 8] = 8'(k);
    debug_signal = p[DEBUG_W-1:0];
    do_dump();

    do_bad(8'h41);

    rand_debug();
    do_step();
    rand_debug();
    do_step();

    rand_debug();
    do_run(10, 1'b0);
    rand_debug();
    do_run(1, 1'b1);

    // hold TX full for 20 edges right after the fifth byte
    rand_debug();
    w0 = wr_cnt;
    push_frame();
    rxq.push_back(8'h64);
    n = 0;
    while (wr_cnt - w0 < 5 && n < 500) begin
      @(negedge clock);
      n++;
    end
    #1 tx_full = 1'b1;
    c = wr_cnt;
    repeat (20) @(negedge clock);
    chk("stall_count", wr_cnt - c, 0);
    #1 tx_full = 1'b0;
    wait_idle("bp");
    chk("bp_len", wr_cnt - w0, NB_TOT);

    // reset while byte 20 of a dump is going out
    rand_debug();
    w0 = wr_cnt;
    push_frame();
    rxq.push_back(8'h64);
    n = 0;
    while (wr_cnt - w0 < 20 && n < 500) begin
      @(negedge clock);
      n++;
    end
    mid_reset("rst_send");
    rand_debug();
    do_dump();

    // reset in the middle of a free run
    rxq.push_back(8'h63);
    cyc(6);
    mid_reset("rst_run");
    rand_debug();
    do_step();

    // randomized commands with random backpressure
    rand_full = 1;
    for (int it = 0; it < 14; it++) begin
      rand_debug();
      case ($urandom_range(0, 4))
        0: do_dump();
        1: do_step();
        2: do_run(int'($urandom_range(1, 25)), 1'b0);
        3: do_run(1, 1'b1);
        default: begin
          dmy = 8'($urandom_range(0, 255));
          if (dmy == 8'h63 || dmy == 8'h73 || dmy == 8'h64) dmy = 8'h00;
          do_bad(dmy);
        end
      endcase
    end
    rand_full = 0;
    cyc(2);
    tx_full = 1'b0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
